// File: rtl/l2_mem_responder.sv
// l2_mem_responder: round-robin two-port L2 word responder backed by a programmable-latency SRAM
module l2_mem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int ACC_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_mem_en,
  input  logic        m0_mem_wr_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  output logic        m0_rd_granted,
  output logic        m0_wr_granted,
  output logic [31:0] m0_rd_data,
  input  logic        m1_mem_en,
  input  logic        m1_mem_wr_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  output logic        m1_rd_granted,
  output logic        m1_wr_granted,
  output logic [31:0] m1_rd_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic port, wr, last;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] wdata;
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic sel;
  logic unused_bits;
  assign unused_bits = ^{m0_addr[31:DEPTH_LOG2+2], m0_addr[1:0], m1_addr[31:DEPTH_LOG2+2], m1_addr[1:0]};
  assign sel = (m0_mem_en && m1_mem_en) ? !last : m1_mem_en;
  assign busy = state != IDLE;
  // a reset landing on the RESP edge must leave the SRAM untouched
  always_ff @(posedge clk)
    if (rst_n && state == RESP && wr) mem[idx] <= wdata;
  always_ff @(posedge clk) begin
    m0_rd_granted <= 1'b0;
    m0_wr_granted <= 1'b0;
    m1_rd_granted <= 1'b0;
    m1_wr_granted <= 1'b0;
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last       <= 1'b1;
      port       <= 1'b0;
      wr         <= 1'b0;
      idx        <= '0;
      wdata      <= 32'd0;
      m0_rd_data <= 32'd0;
      m1_rd_data <= 32'd0;
    end else begin
      case (state)
        IDLE: if (m0_mem_en || m1_mem_en) begin
          port  <= sel;
          wr    <= sel ? m1_mem_wr_en : m0_mem_wr_en;
          idx   <= sel ? m1_addr[DEPTH_LOG2+1:2] : m0_addr[DEPTH_LOG2+1:2];
          wdata <= sel ? m1_wr_data : m0_wr_data;
          cnt   <= 4'(ACC_LAT - 1);
          state <= ACCESS;
        end
        ACCESS: if (cnt == 4'd0) begin
          state         <= RESP;
          m0_rd_granted <= !port && !wr;
          m0_wr_granted <= !port && wr;
          m1_rd_granted <= port && !wr;
          m1_wr_granted <= port && wr;
          if (!wr && !port) m0_rd_data <= mem[idx];
          if (!wr && port) m1_rd_data <= mem[idx];
        end else cnt <= cnt - 4'd1;
        default: begin
          last  <= port;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l2_mem_responder.sv
// tb_l2_mem_responder: directed stimulus with a grant scoreboard checked by an independent monitor
module tb_l2_mem_responder;
  logic clk, rst_n;
  logic m0_mem_en, m0_mem_wr_en, m0_rd_granted, m0_wr_granted;
  logic [31:0] m0_addr, m0_wr_data, m0_rd_data;
  logic m1_mem_en, m1_mem_wr_en, m1_rd_granted, m1_wr_granted;
  logic [31:0] m1_addr, m1_wr_data, m1_rd_data;
  logic busy;
  typedef struct {
    bit port;
    bit wr;
    logic [31:0] data;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;

  l2_mem_responder #(.DEPTH_LOG2(12), .ACC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_mem_en(m0_mem_en), .m0_mem_wr_en(m0_mem_wr_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_rd_granted(m0_rd_granted), .m0_wr_granted(m0_wr_granted), .m0_rd_data(m0_rd_data),
    .m1_mem_en(m1_mem_en), .m1_mem_wr_en(m1_mem_wr_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_rd_granted(m1_rd_granted), .m1_wr_granted(m1_wr_granted), .m1_rd_data(m1_rd_data),
    .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push(input bit p, input bit w, input logic [31:0] d, input int c);
    exp_t e;
    e.port = p;
    e.wr = w;
    e.data = d;
    e.cyc = c;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    logic [3:0] g;
    exp_t e;
    bit p, w;
    g = {m1_rd_granted, m1_wr_granted, m0_rd_granted, m0_wr_granted};
    if (g != 4'd0) begin
      chk($countones(g) == 1, "grant_onehot", 64'(g), 64'd1);
      if (sb.size() == 0) chk(1'b0, "unexpected_grant", 64'(g), 64'd0);
      else begin
        e = sb.pop_front();
        p = m1_rd_granted | m1_wr_granted;
        w = m0_wr_granted | m1_wr_granted;
        chk({p, w} == {e.port, e.wr}, "grant_port_type", 64'({p, w}), 64'({e.port, e.wr}));
        if (!e.wr) chk((p ? m1_rd_data : m0_rd_data) == e.data, "rd_data", 64'(p ? m1_rd_data : m0_rd_data), 64'(e.data));
        if (e.cyc >= 0) chk(cyc == e.cyc, "grant_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // called on a negedge; holds the request until the port is granted
  task automatic drive(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    if (p) begin
      m1_mem_en = 1; m1_mem_wr_en = w; m1_addr = a; m1_wr_data = d;
    end else begin
      m0_mem_en = 1; m0_mem_wr_en = w; m0_addr = a; m0_wr_data = d;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = p ? (m1_rd_granted | m1_wr_granted) : (m0_rd_granted | m0_wr_granted);
    end
    chk(got, "grant_seen", 64'(got), 64'd1);
    if (p) m1_mem_en = 0;
    else m0_mem_en = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 0;
    {m0_mem_en, m0_mem_wr_en, m1_mem_en, m1_mem_wr_en} = '0;
    {m0_addr, m0_wr_data, m1_addr, m1_wr_data} = '0;
    repeat (3) @(negedge clk);
    chk({m0_rd_granted, m0_wr_granted, m1_rd_granted, m1_wr_granted} == 4'd0, "reset_grants", 64'({m0_rd_granted, m0_wr_granted, m1_rd_granted, m1_wr_granted}), 64'd0);
    chk(m0_rd_data == 32'd0 && m1_rd_data == 32'd0, "reset_rd_data", {m0_rd_data, m1_rd_data}, 64'd0);
    chk(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "idle_busy", 64'(busy), 64'd0);
    // single-port write then read back
    c = cyc;
    push(0, 1, 32'h0, c + 3);
    drive(0, 1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    c = cyc;
    push(0, 0, 32'hDEADBEEF, c + 3);
    drive(0, 0, 32'h40, 32'h0);
    chk(m1_rd_data == 32'd0, "m1_rd_data_untouched", 64'(m1_rd_data), 64'd0);
    @(negedge clk);
    // round-robin after a fresh reset
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      push(0, 0, 32'hDEADBEEF, c + 3);
      push(1, 0, 32'hDEADBEEF, c + 7);
      fork
        drive(0, 0, 32'h40, 32'h0);
        drive(1, 0, 32'h40, 32'h0);
      join
      @(negedge clk);
    end
    c = cyc;
    push(0, 0, 32'hDEADBEEF, c + 3);
    push(1, 0, 32'hDEADBEEF, c + 7);
    fork
      drive(0, 0, 32'h40, 32'h0);
      begin
        repeat (2) @(negedge clk);
        drive(1, 0, 32'h40, 32'h0);
      end
    join
    @(negedge clk);
    // address aliasing across the 4096-word window
    push(1, 1, 32'h0, -1);
    drive(1, 1, 32'h4040, 32'h12345678);
    @(negedge clk);
    push(0, 0, 32'h12345678, -1);
    drive(0, 0, 32'h40, 32'h0);
    @(negedge clk);
    // reset during ACCESS aborts a write
    push(0, 1, 32'h0, -1);
    drive(0, 1, 32'h80, 32'h0);
    repeat (2) @(negedge clk);
    m0_mem_en = 1; m0_mem_wr_en = 1; m0_addr = 32'h80; m0_wr_data = 32'hAAAA5555;
    @(negedge clk);
    rst_n = 0;
    m0_mem_en = 0;
    @(negedge clk);
    chk(busy == 1'b0, "abort_busy", 64'(busy), 64'd0);
    chk(m0_rd_data == 32'd0, "abort_rd_data", 64'(m0_rd_data), 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    push(0, 0, 32'h0, -1);
    drive(0, 0, 32'h80, 32'h0);
    repeat (2) @(negedge clk);
    // requester drops mem_en mid-transaction
    c = cyc;
    push(1, 0, 32'h12345678, c + 3);
    m1_mem_en = 1; m1_mem_wr_en = 0; m1_addr = 32'h4040;
    @(negedge clk);
    m1_mem_en = 0;
    repeat (8) @(negedge clk);
    chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
    chk(busy == 1'b0, "final_busy", 64'(busy), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
